brch_ckpt_tracker: RTL

Parametrised branch-checkpoint tracker for the allocation stage. Each cycle it takes a dispatch group of up to WIDTH instructions and records a checkpoint for every branch: the branch's instruction index and the physical-register pointer position just before it. Checkpoints live in an age-ordered circular queue of DEPTH entries. They retire in order on commit. On a misprediction, the mispredicted checkpoint and every younger one are squashed, and the recovery pointer position is returned as `flush_pos`.

---
 rtl/brch_ckpt_tracker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/brch_ckpt_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : brch_ckpt_tracker
//  Purpose  : Branch-checkpoint tracker for the allocation stage. Records
//             {indx, pos} for every branch of a dispatch group in an
//             age-ordered circular queue, retires checkpoints in order on
//             commit and squashes the mispredicted checkpoint plus all
//             younger ones, returning the recovery pointer position.
//  Ports    : clk, rst            - clock, async active-high reset
//             disp_*              - dispatch group (WIDTH slots)
//             nxt_indx, curr_pos  - index / pointer position of slot 0
//             alloc_stall         - group rejected this cycle (comb)
//             cmt_valid/cmt_indx  - in-order branch commit
//             mis_pred/mis_indx   - branch misprediction
//             flush_valid/pos/indx- registered recovery pulse
//             free_cnt            - registered free entry count
//  Revision : 1.0 - initial release
// ============================================================================
module brch_ckpt_tracker #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  parameter int POS_W = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             disp_valid,
  input  logic [WIDTH-1:0]             disp_is_brch,
  input  logic [WIDTH-1:0]             disp_need_pr,
  input  logic [IDX_W-1:0]             nxt_indx,
  input  logic [POS_W-1:0]             curr_pos,
  output logic                         alloc_stall,
  input  logic                         cmt_valid,
  input  logic [IDX_W-1:0]             cmt_indx,
  input  logic                         mis_pred,
  input  logic [IDX_W-1:0]             mis_indx,
  output logic                         flush_valid,
  output logic [POS_W-1:0]             flush_pos,
  output logic [IDX_W-1:0]             flush_indx,
  output logic [$clog2(DEPTH+1)-1:0]   free_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int NB_W  = $clog2(WIDTH+1);

  // Queue storage and pointers
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][IDX_W-1:0] r_indx;
  logic [DEPTH-1:0][POS_W-1:0] r_pos;
  logic [PTR_W-1:0]            r_head;
  logic [PTR_W-1:0]            r_tail;

  // Per-slot derived values
  logic [WIDTH-1:0][IDX_W-1:0] w_slot_indx;
  logic [WIDTH-1:0][POS_W-1:0] w_slot_pos;
  logic [WIDTH-1:0][NB_W-1:0]  w_slot_rank;  // branches in older slots
  logic [POS_W-1:0]            w_pos_acc;
  logic [NB_W-1:0]             w_nb;

  // Event decode and next state
  logic                        w_mis_hit;
  logic [PTR_W-1:0]            w_mis_ptr;
  int                          w_mis_off;
  logic                        w_cmt_ok;
  int                          w_occ;
  int                          w_occ_n;
  logic [DEPTH-1:0]            w_valid_n;
  logic [DEPTH-1:0][IDX_W-1:0] w_indx_n;
  logic [DEPTH-1:0][POS_W-1:0] w_pos_n;
  logic [PTR_W-1:0]            w_head_n;
  logic [PTR_W-1:0]            w_tail_n;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input int n);
    return PTR_W'((int'(p) + n) % DEPTH);
  endfunction

  // Slot index / position / branch rank (lowest slot is oldest)
  always_comb begin
    w_pos_acc   = curr_pos;
    w_nb        = '0;
    w_slot_indx = '0;
    w_slot_pos  = '0;
    w_slot_rank = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_slot_indx[k] = nxt_indx + IDX_W'(k);
      w_slot_pos[k]  = w_pos_acc;
      w_slot_rank[k] = w_nb;
      if (disp_valid[k] && disp_need_pr[k]) w_pos_acc = w_pos_acc + POS_W'(1);
      if (disp_valid[k] && disp_is_brch[k]) w_nb = w_nb + NB_W'(1);
    end
  end

  // Stall decision deliberately uses the registered free count, so a
  // same-cycle commit does not make room until the next cycle.
  assign alloc_stall = mis_pred | (int'(w_nb) > int'(free_cnt));

  always_comb begin
    w_mis_hit = 1'b0;
    w_mis_ptr = '0;
    w_mis_off = 0;
    w_cmt_ok  = 1'b0;
    w_occ     = DEPTH - int'(free_cnt);
    w_occ_n   = w_occ;
    w_valid_n = r_valid;
    w_indx_n  = r_indx;
    w_pos_n   = r_pos;
    w_head_n  = r_head;
    w_tail_n  = r_tail;

    // Valid indices are unique, so at most one entry matches.
    for (int e = 0; e < DEPTH; e++) begin
      if (mis_pred && r_valid[e] && (r_indx[e] == mis_indx)) begin
        w_mis_hit = 1'b1;
        w_mis_ptr = PTR_W'(e);
      end
    end
    // Age of the mispredicted entry = number of older live entries.
    w_mis_off = (int'(w_mis_ptr) + DEPTH - int'(r_head)) % DEPTH;

    // A mispredict on the head itself overrides a same-cycle commit.
    w_cmt_ok = cmt_valid && r_valid[r_head] && (r_indx[r_head] == cmt_indx) &&
               !(w_mis_hit && (w_mis_ptr == r_head));

    if (w_cmt_ok) begin
      w_valid_n[r_head] = 1'b0;
      w_head_n          = ptr_add(r_head, 1);
    end

    if (w_mis_hit) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (((e + DEPTH - int'(r_head)) % DEPTH) >= w_mis_off)
          w_valid_n[e] = 1'b0;
      end
      w_tail_n = w_mis_ptr;
      w_occ_n  = w_mis_off - (w_cmt_ok ? 1 : 0);
    end else begin
      if (!alloc_stall) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (disp_valid[k] && disp_is_brch[k]) begin
            w_valid_n[ptr_add(r_tail, int'(w_slot_rank[k]))] = 1'b1;
            w_indx_n[ptr_add(r_tail, int'(w_slot_rank[k]))]  = w_slot_indx[k];
            w_pos_n[ptr_add(r_tail, int'(w_slot_rank[k]))]   = w_slot_pos[k];
          end
        end
        w_tail_n = ptr_add(r_tail, int'(w_nb));
        w_occ_n  = w_occ + int'(w_nb) - (w_cmt_ok ? 1 : 0);
      end else begin
        w_occ_n  = w_occ - (w_cmt_ok ? 1 : 0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_indx      <= '0;
      r_pos       <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      free_cnt    <= CNT_W'(DEPTH);
      flush_valid <= 1'b0;
      flush_pos   <= '0;
      flush_indx  <= '0;
    end else begin
      r_valid     <= w_valid_n;
      r_indx      <= w_indx_n;
      r_pos       <= w_pos_n;
      r_head      <= w_head_n;
      r_tail      <= w_tail_n;
      free_cnt    <= CNT_W'(DEPTH - w_occ_n);
      flush_valid <= w_mis_hit;
      if (w_mis_hit) begin
        flush_pos  <= r_pos[w_mis_ptr];
        flush_indx <= r_indx[w_mis_ptr];
      end
    end
  end

endmodule
`default_nettype wire
